// File: rtl/work_frame_loader.sv
// Work frame loader: assembles SYNC_BYTE + 52-byte job frames into midstate/work_data/nonce range for the hash core.
// Latency: job outputs and new_work update on the 2nd edge after the last accepted frame byte (checksum byte with WORK_CHECKSUM_EN).
// Backpressure: none; rx_valid is never stalled, so senders leave >= 2 idle cycles between frames.
module work_frame_loader #(
    parameter int unsigned TIMEOUT_CYCLES = 1000000,
    parameter logic [7:0]  SYNC_BYTE      = 8'hA5
) (
    input  logic         hash_clk,
    input  logic         reset_n,
    input  logic [7:0]   rx_byte,
    input  logic         rx_valid,
    output logic [255:0] midstate,
    output logic [95:0]  work_data,
    output logic [31:0]  nonce_min,
    output logic [31:0]  nonce_max,
    output logic         new_work,
    output logic         busy,
    output logic         frame_error
);

    typedef struct packed {
        logic [255:0] midstate;
        logic [95:0]  work_data;
        logic [31:0]  nonce_min;
        logic [31:0]  nonce_max;
    } job_t;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        RECV   = 2'd1,
`ifdef WORK_CHECKSUM_EN
        CHK    = 2'd2,
`endif
        COMMIT = 2'd3
    } state_t;

    localparam int unsigned   TW       = (TIMEOUT_CYCLES < 2) ? 1 : $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [TW-1:0] TMO_LAST = TW'(TIMEOUT_CYCLES - 1);

    state_t        state, state_nxt;
    job_t          staging, job;
    logic [5:0]    byte_cnt;
    logic [TW-1:0] tmo_cnt;
    logic          take_sync, shift_en, err_set, commit_ok, commit_go;
`ifdef WORK_CHECKSUM_EN
    logic [7:0]    csum;
`endif

    always_comb begin
        state_nxt = state;
        take_sync = 1'b0;
        shift_en  = 1'b0;
        err_set   = 1'b0;
        commit_ok = 1'b0;
        case (state)
            IDLE: begin
                if (rx_valid && rx_byte == SYNC_BYTE) begin
                    take_sync = 1'b1;
                    state_nxt = RECV;
                end
            end
            RECV: begin
                if (rx_valid) begin
                    shift_en = 1'b1;
                    if (byte_cnt == 6'd51) begin
`ifdef WORK_CHECKSUM_EN
                        state_nxt = CHK;
`else
                        state_nxt = COMMIT;
`endif
                    end
                end else if (tmo_cnt >= TMO_LAST) begin
                    err_set   = 1'b1;
                    state_nxt = IDLE;
                end
            end
`ifdef WORK_CHECKSUM_EN
            CHK: begin
                if (rx_valid) begin
                    if (rx_byte == csum) begin
                        state_nxt = COMMIT;
                    end else begin
                        err_set   = 1'b1;
                        state_nxt = IDLE;
                    end
                end else if (tmo_cnt >= TMO_LAST) begin
                    err_set   = 1'b1;
                    state_nxt = IDLE;
                end
            end
`endif
            COMMIT: begin
                state_nxt = IDLE;
                if (staging.nonce_min > staging.nonce_max) begin
                    err_set = 1'b1;
                end else begin
                    commit_ok = 1'b1;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge hash_clk or negedge reset_n) begin
        if (!reset_n) begin
            state       <= IDLE;
            staging     <= '0;
            job         <= '0;
            byte_cnt    <= '0;
            tmo_cnt     <= '0;
            commit_go   <= 1'b0;
            new_work    <= 1'b0;
            frame_error <= 1'b0;
`ifdef WORK_CHECKSUM_EN
            csum        <= '0;
`endif
        end else begin
            state <= state_nxt;

            if (take_sync) begin
                byte_cnt <= '0;
`ifdef WORK_CHECKSUM_EN
                csum     <= '0;
`endif
            end else if (shift_en) begin
                byte_cnt <= byte_cnt + 6'd1;
                staging  <= {staging[407:0], rx_byte};
`ifdef WORK_CHECKSUM_EN
                csum     <= csum ^ rx_byte;
`endif
            end

            // Counter only runs while waiting on a byte, and holds once it reaches the limit.
            if (take_sync || shift_en || state == IDLE || state == COMMIT) begin
                tmo_cnt <= '0;
            end else if (tmo_cnt != TMO_LAST) begin
                tmo_cnt <= tmo_cnt + 1'b1;
            end

            if (take_sync) begin
                frame_error <= 1'b0;
            end else if (err_set) begin
                frame_error <= 1'b1;
            end

            // Commit is registered once so outputs and new_work move together one edge after COMMIT.
            commit_go <= commit_ok;
            new_work  <= commit_go;
            if (commit_go) begin
                job <= staging;
            end
        end
    end

    assign midstate  = job.midstate;
    assign work_data = job.work_data;
    assign nonce_min = job.nonce_min;
    assign nonce_max = job.nonce_max;
    assign busy      = (state != IDLE);

endmodule

// File: tb/tb_work_frame_loader.sv
// Scoreboard bench for work_frame_loader: stimulus pushes expected jobs, a negedge monitor checks each new_work.
module tb_work_frame_loader;

    localparam logic [7:0] SYNC = 8'hA5;

    logic         hash_clk = 1'b0;
    logic         reset_n  = 1'b0;
    logic [7:0]   rx_byte  = '0;
    logic         rx_valid = 1'b0;
    logic [255:0] midstate;
    logic [95:0]  work_data;
    logic [31:0]  nonce_min;
    logic [31:0]  nonce_max;
    logic         new_work;
    logic         busy;
    logic         frame_error;

    work_frame_loader #(.TIMEOUT_CYCLES(50), .SYNC_BYTE(SYNC)) dut (
        .hash_clk    (hash_clk),
        .reset_n     (reset_n),
        .rx_byte     (rx_byte),
        .rx_valid    (rx_valid),
        .midstate    (midstate),
        .work_data   (work_data),
        .nonce_min   (nonce_min),
        .nonce_max   (nonce_max),
        .new_work    (new_work),
        .busy        (busy),
        .frame_error (frame_error)
    );

    always #5 hash_clk = ~hash_clk;

    int checks = 0;
    int errors = 0;
    int nw_count = 0;
    logic [415:0] exp_q[$];
    logic [415:0] mon_exp;

    task automatic check(input string name, input logic [255:0] act, input logic [255:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%h expected=%h", name, act, exp);
        end
    endtask

    always @(negedge hash_clk) begin
        if (reset_n === 1'b1 && new_work === 1'b1) begin
            nw_count++;
            if (exp_q.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_new_work actual=1 expected=0");
            end else begin
                mon_exp = exp_q.pop_front();
                check("midstate",  midstate,            mon_exp[415:160]);
                check("work_data", {160'd0, work_data}, {160'd0, mon_exp[159:64]});
                check("nonce_min", {224'd0, nonce_min}, {224'd0, mon_exp[63:32]});
                check("nonce_max", {224'd0, nonce_max}, {224'd0, mon_exp[31:0]});
            end
        end
    end

    function automatic logic [415:0] seq_payload(input logic [7:0] base);
        logic [415:0] p;
        p = '0;
        for (int i = 0; i < 52; i++) p[415-8*i -: 8] = base + 8'(i);
        return p;
    endfunction

    task automatic idle(input int n);
        repeat (n) begin
            @(posedge hash_clk);
            #1;
        end
    endtask

    task automatic send_byte(input logic [7:0] b);
        rx_byte  = b;
        rx_valid = 1'b1;
        @(posedge hash_clk);
        #1;
        rx_valid = 1'b0;
    endtask

    task automatic send_bytes(input logic [415:0] p, input int n);
        for (int i = 0; i < n; i++) begin
            send_byte(p[415-8*i -: 8]);
            if (i % 7 == 3) idle(1);
        end
    endtask

    task automatic send_tail(input logic [415:0] p, input logic [7:0] flip);
`ifdef WORK_CHECKSUM_EN
        logic [7:0] x;
        x = '0;
        for (int i = 0; i < 52; i++) x = x ^ p[415-8*i -: 8];
        send_byte(x ^ flip);
`else
        if (p[0] === 1'bx || flip === 8'hxx) idle(0);
`endif
        idle(4);
    endtask

    task automatic send_frame(input logic [415:0] p, input logic [7:0] flip);
        send_byte(SYNC);
        send_bytes(p, 52);
        send_tail(p, flip);
    endtask

    logic [415:0] p0, p1, p3, p4, last;
    int nw_before;

    initial begin
        p0 = seq_payload(8'h00);
        p1 = seq_payload(8'h40);
        p3 = seq_payload(8'h80);
        p3[63:32] = 32'h0000_1000;
        p3[31:0]  = 32'h0000_0FFF;
        p4 = p3;
        p4[31:0]  = 32'h0000_1000;

        idle(3);
        @(negedge hash_clk);
        check("rst_midstate",  midstate,             256'd0);
        check("rst_work_data", {160'd0, work_data},  256'd0);
        check("rst_nonce_min", {224'd0, nonce_min},  256'd0);
        check("rst_nonce_max", {224'd0, nonce_max},  256'd0);
        check("rst_new_work",  {255'd0, new_work},   256'd0);
        check("rst_busy",      {255'd0, busy},       256'd0);
        check("rst_frame_err", {255'd0, frame_error}, 256'd0);
        @(posedge hash_clk);
        #1;
        reset_n = 1'b1;
        idle(2);

        // Sequential frame 0x00..0x33
        check("p0_literal_nonce_max", p0[255:0] & 256'hFFFF_FFFF, 256'h3031_3233);
        exp_q.push_back(p0);
        send_frame(p0, 8'h00);
        check("p0_frame_error", {255'd0, frame_error}, 256'd0);
        check("p0_new_work_cnt", 256'(nw_count), 256'd1);

        // Junk bytes before sync are ignored
        send_byte(8'h00);
        send_byte(8'h11);
        send_byte(8'hFF);
        idle(2);
        check("junk_busy", {255'd0, busy}, 256'd0);
        exp_q.push_back(p1);
        send_frame(p1, 8'h00);
        check("p1_new_work_cnt", 256'(nw_count), 256'd2);
        last = p1;

        // Timeout mid-frame
        nw_before = nw_count;
        send_byte(SYNC);
        send_bytes(p0, 20);
        idle(55);
        check("tmo_frame_error", {255'd0, frame_error}, 256'd1);
        check("tmo_busy",        {255'd0, busy},        256'd0);
        check("tmo_no_new_work", 256'(nw_count),        256'(nw_before));
        check("tmo_job_kept",    midstate,              last[415:160]);
        send_byte(SYNC);
        check("sync_clears_err", {255'd0, frame_error}, 256'd0);
        check("sync_busy",       {255'd0, busy},        256'd1);
        exp_q.push_back(p0);
        send_bytes(p0, 52);
        send_tail(p0, 8'h00);
        check("after_tmo_new_work", 256'(nw_count), 256'(nw_before + 1));
        last = p0;

        // nonce_min > nonce_max is rejected
        nw_before = nw_count;
        send_frame(p3, 8'h00);
        check("badnonce_frame_error", {255'd0, frame_error}, 256'd1);
        check("badnonce_no_new_work", 256'(nw_count), 256'(nw_before));
        check("badnonce_nonce_min",   {224'd0, nonce_min}, {224'd0, last[63:32]});
        check("badnonce_midstate",    midstate, last[415:160]);
        exp_q.push_back(p4);
        send_frame(p4, 8'h00);
        check("eqnonce_frame_error", {255'd0, frame_error}, 256'd0);
        check("eqnonce_new_work",    256'(nw_count), 256'(nw_before + 1));

        // Reset in the middle of a frame
        nw_before = nw_count;
        send_byte(SYNC);
        send_bytes(p1, 30);
        reset_n = 1'b0;
        @(negedge hash_clk);
        check("mrst_midstate",  midstate,            256'd0);
        check("mrst_nonce_max", {224'd0, nonce_max}, 256'd0);
        check("mrst_busy",      {255'd0, busy},      256'd0);
        @(posedge hash_clk);
        #1;
        reset_n = 1'b1;
        idle(2);
        check("mrst_no_new_work", 256'(nw_count), 256'(nw_before));
        exp_q.push_back(p0);
        send_frame(p0, 8'h00);
        check("mrst_reload", 256'(nw_count), 256'(nw_before + 1));

`ifdef WORK_CHECKSUM_EN
        nw_before = nw_count;
        send_frame(p0, 8'h01);
        check("csum_bad_err",  {255'd0, frame_error}, 256'd1);
        check("csum_bad_nw",   256'(nw_count), 256'(nw_before));
        exp_q.push_back(p0);
        send_frame(p0, 8'h00);
        check("csum_good_err", {255'd0, frame_error}, 256'd0);
        check("csum_good_nw",  256'(nw_count), 256'(nw_before + 1));
`endif

        idle(5);
        check("scoreboard_drained", 256'(exp_q.size()), 256'd0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
